// File: rtl/control_fsm.sv
// Multi-cycle instruction sequencer: fetches a byte-wide instruction, decodes it,
// steers the ALU / writeback mux, and updates the program counter.
module control_fsm #(
    parameter int bits = 8
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [bits-1:0] instr,
    input  logic            instr_valid,
    input  logic            zero,
    output logic [bits-1:0] pc,
    output logic            instr_req,
    output logic [1:0]      alu_op,
    output logic            s_reg,
    output logic [bits-1:0] imm_out,
    output logic            reg_we,
    output logic [1:0]      reg_addr,
    output logic            halted
);

    // state     | meaning
    // S_FETCH   | request instruction, wait for instr_valid
    // S_DECODE  | IR valid, decoded controls on outputs
    // S_EXECUTE | resolve JZ/NOP, or advance ALU/LDI to writeback
    // S_WBACK   | one-cycle register write, pc+1
    // S_HALT    | stopped until reset
    localparam logic [2:0] S_FETCH   = 3'd0;
    localparam logic [2:0] S_DECODE  = 3'd1;
    localparam logic [2:0] S_EXECUTE = 3'd2;
    localparam logic [2:0] S_WBACK   = 3'd3;
    localparam logic [2:0] S_HALT    = 3'd4;

    localparam logic [2:0] OP_LDI  = 3'b100;
    localparam logic [2:0] OP_JZ   = 3'b101;
    localparam logic [2:0] OP_NOP  = 3'b110;
    localparam logic [2:0] OP_HALT = 3'b111;

    logic [2:0]      state;
    logic [7:0]      ir;
    logic [2:0]      ir_op;
    logic [2:0]      new_op;
    logic [bits-1:0] pc_inc;
    logic [bits-1:0] pc_jump;

    assign ir_op   = ir[7:5];
    assign new_op  = instr[7:5];
    assign pc_inc  = pc + bits'(1);
    assign pc_jump = {{(bits-5){1'b0}}, ir[4:0]};

    // Decoded controls are captured together with IR so they are already
    // valid during DECODE and stay put until the next fetch.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= S_FETCH;
            pc       <= '0;
            ir       <= '0;
            alu_op   <= 2'b00;
            s_reg    <= 1'b0;
            imm_out  <= '0;
            reg_addr <= 2'b00;
        end else begin
            case (state)
                S_FETCH: begin
                    if (instr_valid) begin
                        ir       <= instr[7:0];
                        alu_op   <= new_op[2] ? 2'b00 : new_op[1:0];
                        reg_addr <= instr[4:3];
                        s_reg    <= (new_op == OP_LDI);
                        imm_out  <= (new_op == OP_LDI) ? {{(bits-3){1'b0}}, instr[2:0]} : '0;
                        state    <= S_DECODE;
                    end
                end
                S_DECODE: begin
                    state <= (ir_op == OP_HALT) ? S_HALT : S_EXECUTE;
                end
                S_EXECUTE: begin
                    case (ir_op)
                        OP_JZ: begin
                            pc    <= zero ? pc_jump : pc_inc;
                            state <= S_FETCH;
                        end
                        OP_NOP: begin
                            pc    <= pc_inc;
                            state <= S_FETCH;
                        end
                        OP_HALT: state <= S_HALT;
                        default: state <= S_WBACK;
                    endcase
                end
                S_WBACK: begin
                    pc    <= pc_inc;
                    state <= S_FETCH;
                end
                S_HALT:  state <= S_HALT;
                default: state <= S_FETCH;
            endcase
        end
    end

    assign instr_req = (state == S_FETCH);
    assign reg_we    = (state == S_WBACK);
    assign halted    = (state == S_HALT);

endmodule

// File: tb/tb_control_fsm.sv
// Bench for control_fsm: instruction-level reference model with per-cycle
// comparison, directed scenarios with literal expectations, then random traffic.
module tb_control_fsm;

    localparam int BITS = 8;

    logic            clk = 1'b0;
    logic            reset = 1'b0;
    logic [BITS-1:0] instr = '0;
    logic            instr_valid = 1'b0;
    logic            zero = 1'b0;
    logic [BITS-1:0] pc;
    logic            instr_req;
    logic [1:0]      alu_op;
    logic            s_reg;
    logic [BITS-1:0] imm_out;
    logic            reg_we;
    logic [1:0]      reg_addr;
    logic            halted;

    control_fsm #(.bits(BITS)) dut (
        .clk(clk), .reset(reset), .instr(instr), .instr_valid(instr_valid),
        .zero(zero), .pc(pc), .instr_req(instr_req), .alu_op(alu_op),
        .s_reg(s_reg), .imm_out(imm_out), .reg_we(reg_we),
        .reg_addr(reg_addr), .halted(halted)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: instruction-level view. m_pos counts cycles spent in the
    // current instruction (0 = waiting for a fetch); an instruction of length L
    // retires when m_pos reaches L.
    int        m_pc;
    bit        m_halt;
    int        m_pos;
    bit [7:0]  m_ir;

    function automatic int ilen(input bit [2:0] op);
        if (op <= 3'd4) return 4;
        if (op == 3'd7) return 2;
        return 3;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_check();
        bit [2:0] op;
        op = m_ir[7:5];
        chk("pc", 32'(pc), 32'(m_pc));
        chk("instr_req", 32'(instr_req), 32'(!m_halt && m_pos == 0));
        chk("halted", 32'(halted), 32'(m_halt));
        chk("reg_we", 32'(reg_we), 32'(!m_halt && m_pos == 3));
        if (!m_halt && m_pos != 0) begin
            chk("alu_op", 32'(alu_op), (op < 3'd4) ? 32'(op % 4) : 32'd0);
            chk("s_reg", 32'(s_reg), 32'(op == 3'd4));
            chk("imm_out", 32'(imm_out), (op == 3'd4) ? 32'(m_ir[2:0]) : 32'd0);
            chk("reg_addr", 32'(reg_addr), 32'(m_ir[4:3]));
        end
    endtask

    function automatic void model_reset();
        m_pc = 0; m_halt = 0; m_pos = 0; m_ir = '0;
    endfunction

    // Called at a negedge: drive inputs, predict the next posedge, compare after it.
    task automatic cyc(input bit v, input bit [7:0] i, input bit z);
        bit [2:0] op;
        instr = BITS'(i); instr_valid = v; zero = z;
        if (!m_halt) begin
            if (m_pos == 0) begin
                if (v) begin
                    m_ir = i;
                    m_pos = 1;
                end
            end else begin
                op = m_ir[7:5];
                m_pos++;
                if (m_pos == ilen(op)) begin
                    m_pos = 0;
                    if (op == 3'd7) m_halt = 1;
                    else if (op == 3'd5 && z) m_pc = int'(m_ir[4:0]);
                    else m_pc = (m_pc + 1) % (1 << BITS);
                end
            end
        end
        @(negedge clk);
        model_check();
    endtask

    task automatic run_instr(input bit [7:0] i, input bit z, output int ncyc);
        int guard;
        cyc(1'b1, i, z);
        ncyc = 1;
        guard = 0;
        while (m_pos != 0 && !m_halt && guard < 10) begin
            cyc(1'($urandom), 8'($urandom), z);
            ncyc++;
            guard++;
        end
        if (guard >= 10) chk("instr_timeout", 32'(guard), 32'd0);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        instr_valid = 1'b0;
        #1;
        chk("rst_pc", 32'(pc), 32'd0);
        chk("rst_instr_req", 32'(instr_req), 32'd1);
        chk("rst_reg_we", 32'(reg_we), 32'd0);
        chk("rst_halted", 32'(halted), 32'd0);
        chk("rst_alu_op", 32'(alu_op), 32'd0);
        chk("rst_s_reg", 32'(s_reg), 32'd0);
        chk("rst_imm_out", 32'(imm_out), 32'd0);
        chk("rst_reg_addr", 32'(reg_addr), 32'd0);
        model_reset();
        @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        int n;
        int halt_cnt;
        bit [7:0] ri;
        model_reset();
        @(negedge clk);
        do_reset();
        model_check();

        // LDI r0,5
        cyc(1'b1, 8'h85, 1'b0);
        chk("ldi_s_reg", 32'(s_reg), 32'd1);
        chk("ldi_imm", 32'(imm_out), 32'h05);
        chk("ldi_rd", 32'(reg_addr), 32'd0);
        chk("ldi_we_dec", 32'(reg_we), 32'd0);
        cyc(1'b1, 8'hFF, 1'b0);
        cyc(1'b1, 8'hFF, 1'b0);
        chk("ldi_we_wb", 32'(reg_we), 32'd1);
        cyc(1'b0, 8'h00, 1'b0);
        chk("ldi_we_after", 32'(reg_we), 32'd0);
        chk("ldi_pc", 32'(pc), 32'd1);

        // SUB r3
        cyc(1'b1, 8'h38, 1'b0);
        chk("sub_alu", 32'(alu_op), 32'd1);
        chk("sub_rd", 32'(reg_addr), 32'd3);
        chk("sub_s_reg", 32'(s_reg), 32'd0);
        cyc(1'b0, 8'h00, 1'b0);
        cyc(1'b0, 8'h00, 1'b0);
        chk("sub_we", 32'(reg_we), 32'd1);
        cyc(1'b0, 8'h00, 1'b0);
        chk("sub_pc", 32'(pc), 32'd2);

        // JZ 0x14 taken, then not taken
        run_instr(8'hB4, 1'b1, n);
        chk("jz_taken_pc", 32'(pc), 32'h14);
        chk("jz_cycles", 32'(n), 32'd3);
        run_instr(8'hB4, 1'b0, n);
        chk("jz_fall_pc", 32'(pc), 32'h15);

        // Fetch stall
        for (int k = 0; k < 5; k++) begin
            cyc(1'b0, 8'($urandom), 1'($urandom));
            chk("stall_pc", 32'(pc), 32'h15);
            chk("stall_req", 32'(instr_req), 32'd1);
        end
        run_instr(8'h1A, 1'b0, n);
        chk("add_cycles", 32'(n), 32'd4);
        chk("add_pc", 32'(pc), 32'h16);

        // pc wrap via NOPs, then HALT
        do_reset();
        for (int k = 0; k < 255; k++) run_instr(8'hC0, 1'($urandom), n);
        chk("nop_pc_ff", 32'(pc), 32'hFF);
        run_instr(8'hC0, 1'b0, n);
        chk("nop_wrap_pc", 32'(pc), 32'h00);
        run_instr(8'hE0, 1'b0, n);
        chk("halt_cycles", 32'(n), 32'd2);
        for (int k = 0; k < 8; k++) cyc(1'b1, 8'($urandom), 1'($urandom));
        chk("halt_flag", 32'(halted), 32'd1);
        chk("halt_req", 32'(instr_req), 32'd0);
        chk("halt_pc", 32'(pc), 32'd0);

        // Reset in the middle of WRITEBACK
        do_reset();
        cyc(1'b1, 8'h4D, 1'b0);
        cyc(1'b0, 8'h00, 1'b0);
        cyc(1'b0, 8'h00, 1'b0);
        chk("mid_wb_we", 32'(reg_we), 32'd1);
        #2;
        reset = 1'b1;
        #1;
        chk("mid_wb_we_abort", 32'(reg_we), 32'd0);
        chk("mid_wb_pc", 32'(pc), 32'd0);
        chk("mid_wb_req", 32'(instr_req), 32'd1);
        model_reset();
        @(negedge clk);
        reset = 1'b0;
        model_check();

        // Random traffic with occasional resets at arbitrary points
        halt_cnt = 0;
        for (int k = 0; k < 6000; k++) begin
            if (m_halt) halt_cnt++;
            if ((m_halt && halt_cnt > 4) || ($urandom % 300 == 0)) begin
                do_reset();
                halt_cnt = 0;
                model_check();
            end else begin
                ri = 8'($urandom);
                if (ri[7:5] == 3'b111 && ($urandom % 4 != 0)) ri[7:5] = 3'b110;
                cyc(($urandom % 3) != 0, ri, 1'($urandom));
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/control_fsm.md
CONTROL_FSM -- requirements
Module: control_fsm

Interface
REQ-001 SHALL have parameter bits, default 8, datapath/PC/instruction width (minimum 8).
REQ-002 SHALL have port clk  input  1  single clock; all state changes on rising edge.
REQ-003 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port instr  input  bits  instruction byte from memory, sampled only when instr_valid=1 in FETCH.
REQ-005 SHALL have port instr_valid  input  1  memory has instr ready for current pc.
REQ-006 SHALL have port zero  input  1  ALU zero flag from datapath, sampled in EXECUTE.
REQ-007 SHALL have port pc  output  bits  program counter / instruction address.
REQ-008 SHALL have port instr_req  output  1  fetch request, high only in FETCH.
REQ-009 SHALL have port alu_op  output  2  ALU operation: 00 ADD, 01 SUB, 10 AND, 11 OR.
REQ-010 SHALL have port s_reg  output  1  writeback mux select: 1 = imm_out, 0 = ALU result.
REQ-011 SHALL have port imm_out  output  bits  immediate driven to writeback mux.
REQ-012 SHALL have port reg_we  output  1  register-file write enable.
REQ-013 SHALL have port reg_addr  output  2  destination register index.
REQ-014 SHALL have port halted  output  1  controller stopped.

Function
REQ-015 Instruction format SHALL be: opcode = instr[7:5], rd = instr[4:3], field = instr[2:0]; bits above 7 ignored.
REQ-016 Opcodes SHALL be: 000 ADD, 001 SUB, 010 AND, 011 OR, 100 LDI, 101 JZ, 110 NOP, 111 HALT.
REQ-017 States SHALL be FETCH, DECODE, EXECUTE, WRITEBACK, HALT; one state per cycle except FETCH waiting.
REQ-018 FETCH: instr_req=1; if instr_valid=1, latch instr into internal IR, go DECODE; else stay FETCH, pc unchanged.
REQ-019 DECODE: drive alu_op, reg_addr, s_reg, imm_out from IR; go EXECUTE, except HALT opcode goes HALT.
REQ-020 alu_op SHALL equal opcode[1:0] for opcodes 000-011 and 00 otherwise; reg_addr SHALL equal rd.
REQ-021 LDI: s_reg=1, imm_out = field zero-extended to bits; all other opcodes s_reg=0, imm_out=0.
REQ-022 EXECUTE, JZ with zero=1: pc <= {instr[4:0]} zero-extended, go FETCH (no WRITEBACK).
REQ-023 EXECUTE, JZ with zero=0 or NOP: pc <= pc+1, go FETCH.
REQ-024 EXECUTE, ADD/SUB/AND/OR/LDI: go WRITEBACK.
REQ-025 WRITEBACK: reg_we=1 for exactly this one cycle; pc <= pc+1; go FETCH.
REQ-026 reg_we SHALL be 0 in every state other than WRITEBACK.
REQ-027 alu_op, s_reg, imm_out, reg_addr SHALL hold stable from DECODE through WRITEBACK.
REQ-028 pc increment SHALL wrap modulo 2^bits (all-ones -> 0).
REQ-029 HALT state: halted=1, instr_req=0, reg_we=0, pc frozen; exit only via reset.
REQ-030 Cycle count: ALU/LDI instruction = 4 cycles with zero-wait memory; JZ/NOP = 3; HALT = 2 to reach HALT.
REQ-031 instr_valid outside FETCH SHALL be ignored.

Reset
REQ-032 reset=1 SHALL asynchronously force state FETCH, pc=0, IR=0, alu_op=00, s_reg=0, imm_out=0, reg_we=0, reg_addr=0, halted=0.
REQ-033 instr_req SHALL be 1 while in FETCH after reset, including during reset assertion.
REQ-034 Reset mid-instruction (any state, including HALT and WRITEBACK) SHALL abort it with no reg_we pulse.

Verification
REQ-035 Reset, instr=0x85 (LDI r0,5) valid at cycle 0 -> DECODE s_reg=1 imm_out=0x05 reg_addr=0; WRITEBACK reg_we=1 one cycle; pc=1.
REQ-036 instr=0x38 (SUB r3) -> alu_op=01 reg_addr=3 s_reg=0, reg_we single pulse at cycle 4, pc +1.
REQ-037 instr=0xB4 (JZ 0x14) with zero=1 -> pc=0x14, no reg_we; repeat with zero=0 -> pc incremented.
REQ-038 instr_valid held 0 for 5 cycles in FETCH -> pc and state unchanged, instr_req=1 throughout; then valid -> normal decode.
REQ-039 pc=0xFF executing NOP -> pc=0x00; instr=0xE0 (HALT) -> halted=1 indefinitely, instr_req=0.
REQ-040 reset asserted mid-cycle during WRITEBACK -> immediate return to reset values, no completed write.
